// File: rtl/interval_fill.sv
// interval_fill: walks scanlines y_top..y_bot, asks an external combinational
// generator for the [line_s, line_t] span of each line and emits one pixel
// write per covered x with a valid/ready handshake.
// Optional build macro INTERVAL_FILL_CLIP_EN clips every span to x < H_RES.
module interval_fill #(
  parameter int CORDW = 9,
  parameter int COLRW = 4,
  parameter int H_RES = 320
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CORDW-1:0] y_top,
  input  logic [CORDW-1:0] y_bot,
  input  logic [COLRW-1:0] colr,
  output logic [CORDW-1:0] line_y,
  input  logic [CORDW-1:0] line_s,
  input  logic [CORDW-1:0] line_t,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [CORDW-1:0] pix_x,
  output logic [CORDW-1:0] pix_y,
  output logic [COLRW-1:0] pix_colr,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, LOAD, DRAW, NEXT, FIN} state_t;

  state_t           state, state_nx;
  logic [CORDW-1:0] x_cur, x_end, y_end;
  logic [COLRW-1:0] colr_q;
  logic [CORDW-1:0] ld_end;
  logic             ld_empty;

`ifdef INTERVAL_FILL_CLIP_EN
  localparam logic [CORDW-1:0] XMAX = CORDW'(H_RES - 1);

  // Clip span end to the last visible column; a start beyond it leaves s > end.
  always_comb begin
    ld_end   = (line_t > XMAX) ? XMAX : line_t;
    ld_empty = (line_s > ld_end);
  end
`else
  // Span is taken as-is from the generator.
  always_comb begin
    ld_end   = line_t;
    ld_empty = (line_s > line_t);
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; ends of line/shape found by equality so nothing wraps.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (y_top <= y_bot) ? LOAD : FIN;
      LOAD: state_nx = ld_empty ? NEXT : DRAW;
      DRAW: if (pix_ready && x_cur == x_end) state_nx = NEXT;
      NEXT: state_nx = (line_y == y_end) ? FIN : LOAD;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch the request, load spans, step x within a line and y between lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_y <= '0;
      y_end  <= '0;
      colr_q <= '0;
      x_cur  <= '0;
      x_end  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          line_y <= y_top;
          y_end  <= y_bot;
          colr_q <= colr;
        end
        LOAD: begin
          x_cur <= line_s;
          x_end <= ld_end;
        end
        DRAW: if (pix_ready && x_cur != x_end) x_cur <= x_cur + 1'b1;
        NEXT: if (line_y != y_end) line_y <= line_y + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state, so they drop with reset immediately.
  assign pix_valid = (state == DRAW);
  assign pix_x     = x_cur;
  assign pix_y     = line_y;
  assign pix_colr  = colr_q;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

endmodule

// File: tb/tb_interval_fill.sv
// Bench for interval_fill: expected pixels go into a queue when a fill is
// requested and are popped as the DUT transfers them.
module tb_interval_fill;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [8:0] y_top, y_bot;
  logic [3:0] colr;
  logic [8:0] line_y;
  logic [8:0] line_s, line_t;
  logic       pix_valid, pix_ready;
  logic [8:0] pix_x, pix_y;
  logic [3:0] pix_colr;
  logic       busy, done;

  logic [8:0] s_val, t_val;
  assign line_s = s_val;
  assign line_t = t_val;

  interval_fill dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y_top(y_top), .y_bot(y_bot),
    .colr(colr), .line_y(line_y), .line_s(line_s), .line_t(line_t),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_colr(pix_colr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int npix   = 0;
  int ndone  = 0;
  logic [21:0] sb[$];

  logic       stall_prev = 1'b0;
  logic [8:0] px_prev, py_prev;
  logic [3:0] pc_prev;

  // Monitor: scoreboard on transfers, stability during stalls, done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid && pix_ready) begin
        checks++;
        npix++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_pixel got x=%0d y=%0d, none expected", pix_x, pix_y);
        end else begin
          logic [21:0] e;
          e = sb.pop_front();
          if ({pix_x, pix_y, pix_colr} !== e) begin
            errors++;
            $display("FAIL pixel got x=%0d y=%0d c=%0d, want x=%0d y=%0d c=%0d",
                     pix_x, pix_y, pix_colr, e[21:13], e[12:4], e[3:0]);
          end
        end
      end
      if (stall_prev) begin
        checks++;
        if (!pix_valid || pix_x !== px_prev || pix_y !== py_prev || pix_colr !== pc_prev) begin
          errors++;
          $display("FAIL stall_hold got v=%0b x=%0d y=%0d, want v=1 x=%0d y=%0d",
                   pix_valid, pix_x, pix_y, px_prev, py_prev);
        end
      end
      stall_prev = pix_valid && !pix_ready;
      px_prev = pix_x; py_prev = pix_y; pc_prev = pix_colr;
      if (done) ndone++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push_shape(input int yt, input int yb, input int s, input int t,
                            input int xmax, input logic [3:0] c);
    for (int y = yt; y <= yb; y++)
      for (int x = s; x <= ((t < xmax) ? t : xmax); x++)
        sb.push_back({9'(x), 9'(y), c});
  endtask

  // Pulse start, then wait for done (bounded); cyc counts edges after start.
  task automatic run_fill(input logic [8:0] yt, input logic [8:0] yb, input logic [3:0] c,
                          input bit bp, output int cyc, output bit to);
    int k;
    @(posedge clk); #1;
    start = 1'b1; y_top = yt; y_bot = yb; colr = c;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; k = 0;
    while (!done && cyc < 2000) begin
      if (bp) begin pix_ready = (k % 3 == 0); k++; end
      @(posedge clk); #1;
      cyc++;
    end
    to = !done;
    pix_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; pix_ready = 1'b1;
    y_top = '0; y_bot = '0; colr = '0; s_val = '0; t_val = '0;
    #12;
    checks++;
    if ({busy, done, pix_valid, line_y, pix_x, pix_y, pix_colr} !== 33'd0) begin
      errors++;
      $display("FAIL reset_outputs got b=%0b d=%0b v=%0b ly=%0d x=%0d y=%0d c=%0d, want all 0",
               busy, done, pix_valid, line_y, pix_x, pix_y, pix_colr);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_square;
    int cyc; bit to; int d0;
    s_val = 9'd5; t_val = 9'd7; d0 = ndone;
    push_shape(10, 12, 5, 7, 511, 4'hA);
    run_fill(9'd10, 9'd12, 4'hA, 1'b0, cyc, to);
    checks++;
    if (to || cyc != 16) begin
      errors++; $display("FAIL square_cycles got %0d (timeout=%0b), want 16", cyc, to);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ndone - d0 != 1) begin
      errors++; $display("FAIL square_done got done=%0b busy=%0b pulses=%0d, want 0 0 1", done, busy, ndone - d0);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL square_left got %0d pending, want 0", sb.size());
    end
  endtask

  task automatic test_empty_line;
    int cyc; bit to; int p0;
    s_val = 9'd1; t_val = 9'd0; p0 = npix;
    run_fill(9'd20, 9'd20, 4'h3, 1'b0, cyc, to);
    checks++;
    if (to || cyc > 3 || npix != p0) begin
      errors++; $display("FAIL empty_line got cyc=%0d pix=%0d, want cyc<=3 pix=0", cyc, npix - p0);
    end
  endtask

  task automatic test_backpressure;
    int cyc; bit to; int p0;
    s_val = 9'd0; t_val = 9'd3; p0 = npix;
    push_shape(7, 7, 0, 3, 511, 4'h5);
    run_fill(9'd7, 9'd7, 4'h5, 1'b1, cyc, to);
    checks++;
    if (to || npix - p0 != 4 || sb.size() != 0) begin
      errors++; $display("FAIL backpressure got xfers=%0d pending=%0d, want 4 0", npix - p0, sb.size());
    end
  endtask

  task automatic test_boundary;
    int cyc; bit to;
    s_val = 9'd509; t_val = 9'd511;
    push_shape(511, 511, 509, 511, 511, 4'hF);
    run_fill(9'd511, 9'd511, 4'hF, 1'b0, cyc, to);
    checks++;
    if (to || cyc != 6 || sb.size() != 0) begin
      errors++; $display("FAIL boundary got cyc=%0d pending=%0d, want 6 0", cyc, sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || pix_valid !== 1'b0) begin
      errors++; $display("FAIL boundary_idle got busy=%0b v=%0b, want 0 0", busy, pix_valid);
    end
  endtask

  task automatic test_inverted_and_abort;
    int cyc; bit to; int d0, p0, n;
    run_fill(9'd30, 9'd29, 4'h1, 1'b0, cyc, to);
    checks++;
    if (to || cyc != 1) begin
      errors++; $display("FAIL inverted got cyc=%0d, want 1", cyc);
    end
    // Second fill aborted by reset during DRAW.
    s_val = 9'd0; t_val = 9'd50;
    push_shape(40, 45, 0, 50, 511, 4'h6);
    @(posedge clk); #1;
    start = 1'b1; y_top = 9'd40; y_bot = 9'd45; colr = 4'h6;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!pix_valid && n < 20) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (n >= 20 || pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort got v=%0b busy=%0b done=%0b, want 0 0 0", pix_valid, busy, done);
    end
    sb.delete();
    d0 = ndone; p0 = npix;
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (ndone != d0 || npix != p0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_after got done=%0d pix=%0d busy=%0b, want 0 0 0", ndone - d0, npix - p0, busy);
    end
  endtask

`ifdef INTERVAL_FILL_CLIP_EN
  task automatic test_clip;
    int cyc; bit to; int p0;
    s_val = 9'd318; t_val = 9'd330; p0 = npix;
    push_shape(50, 50, 318, 330, 319, 4'h2);
    run_fill(9'd50, 9'd50, 4'h2, 1'b0, cyc, to);
    checks++;
    if (to || npix - p0 != 2 || sb.size() != 0) begin
      errors++; $display("FAIL clip_partial got pix=%0d pending=%0d, want 2 0", npix - p0, sb.size());
    end
    s_val = 9'd400; t_val = 9'd410; p0 = npix;
    run_fill(9'd51, 9'd51, 4'h2, 1'b0, cyc, to);
    checks++;
    if (to || npix != p0) begin
      errors++; $display("FAIL clip_offscreen got pix=%0d, want 0", npix - p0);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_square;
    test_empty_line;
    test_backpressure;
    test_boundary;
    test_inverted_and_abort;
`ifdef INTERVAL_FILL_CLIP_EN
    test_clip;
`endif
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
